// File: rtl/dmem_param_if.sv
// Request/response bundle between the cache miss/writeback path and dmem_param.
// The master drives requests and the slave (the memory) returns status and data.
interface dmem_param_if #(
    parameter int ADDR_WIDTH  = 16,
    parameter int BLOCK_WIDTH = 128,
    parameter int WORD_WIDTH  = 32
);
    localparam int WORDS = BLOCK_WIDTH / WORD_WIDTH;

    logic                   ren;
    logic                   wen;
    logic [ADDR_WIDTH-1:0]  block_address;
    logic [BLOCK_WIDTH-1:0] din;
    logic [WORDS-1:0]       wmask;
    logic                   ready;
    logic                   done;
    logic                   err;
    logic [BLOCK_WIDTH-1:0] dout;

    modport master (
        output ren, wen, block_address, din, wmask,
        input  ready, done, err, dout
    );

    modport slave (
        input  ren, wen, block_address, din, wmask,
        output ready, done, err, dout
    );
endinterface

// File: rtl/dmem_param.sv
// Multi-cycle block data memory with per-word write mask, configurable
// read/write latency and an error response for out-of-range block addresses.
module dmem_param #(
    parameter int ADDR_WIDTH    = 16,
    parameter int BLOCK_WIDTH   = 128,
    parameter int WORD_WIDTH    = 32,
    parameter int DEPTH         = 1024,
    parameter int READ_LATENCY  = 10,
    parameter int WRITE_LATENCY = 10
) (
    input  logic         clock,
    input  logic         reset,
    dmem_param_if.slave  bus
);
    localparam int WORDS  = BLOCK_WIDTH / WORD_WIDTH;
    localparam int MAXLAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int CW     = (MAXLAT > 1) ? $clog2(MAXLAT) : 1;
    localparam int IW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CW-1:0] RD_LOAD = CW'(READ_LATENCY - 1);
    localparam logic [CW-1:0] WR_LOAD = CW'(WRITE_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   ready_q, ready_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic [BLOCK_WIDTH-1:0] dout_q;

    logic                   wr_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [BLOCK_WIDTH-1:0] din_q;
    logic [WORDS-1:0]       wmask_q;

    logic [BLOCK_WIDTH-1:0] mem [DEPTH];

    logic                   accept;
    logic                   acc_wr;
    logic                   acc_lat1;
    logic                   finish;
    logic                   fin_direct;
    logic                   op_wr;
    logic [ADDR_WIDTH-1:0]  op_addr;
    logic [BLOCK_WIDTH-1:0] op_din;
    logic [WORDS-1:0]       op_mask;
    logic                   op_ok;
    logic [IW-1:0]          op_idx;
    logic                   mem_we;
    logic                   rd_load;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return {1'b0, a} < (ADDR_WIDTH+1)'(DEPTH);
    endfunction

    // Write wins over read when both are requested in the same cycle.
    assign accept   = (state_q == IDLE) && ready_q && (bus.ren || bus.wen);
    assign acc_wr   = bus.wen;
    assign acc_lat1 = acc_wr ? (WRITE_LATENCY == 1) : (READ_LATENCY == 1);

    // A latency of 1 completes at the acceptance edge, so the operation must
    // come straight from the request inputs rather than the captured copy.
    assign fin_direct = accept && acc_lat1;
    assign finish     = fin_direct || ((state_q == BUSY) && (cnt_q == '0));

    assign op_wr   = fin_direct ? acc_wr            : wr_q;
    assign op_addr = fin_direct ? bus.block_address : addr_q;
    assign op_din  = fin_direct ? bus.din           : din_q;
    assign op_mask = fin_direct ? bus.wmask         : wmask_q;
    assign op_ok   = in_range(op_addr);
    assign op_idx  = op_addr[IW-1:0];

    assign mem_we  = finish && op_wr && op_ok;
    assign rd_load = finish && !op_wr && op_ok;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (accept) begin
                    ready_d = 1'b0;
                    if (acc_lat1) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        err_d   = !op_ok;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = acc_wr ? WR_LOAD : RD_LOAD;
                    end
                end
            end
            BUSY: begin
                ready_d = 1'b0;
                if (cnt_q == '0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    err_d   = !op_ok;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            err_q   <= err_d;
            if (accept) begin
                wr_q <= acc_wr;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            addr_q  <= bus.block_address;
            din_q   <= bus.din;
            wmask_q <= bus.wmask;
        end
    end

    // Reset gates the write so an operation aborted by reset leaves memory intact.
    always_ff @(posedge clock) begin
        if (reset && mem_we) begin
            for (int w = 0; w < WORDS; w++) begin
                if (op_mask[w]) begin
                    mem[op_idx][w*WORD_WIDTH +: WORD_WIDTH] <= op_din[w*WORD_WIDTH +: WORD_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            dout_q <= '0;
        end else if (rd_load) begin
            dout_q <= mem[op_idx];
        end
    end

    assign bus.ready = ready_q;
    assign bus.done  = done_q;
    assign bus.err   = err_q;
    assign bus.dout  = dout_q;
endmodule
